// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read bus between the fetch unit (master) and instruction memory (slave).
interface instr_fetch_unit_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (output mem_req, output mem_addr, input mem_rdata, input mem_ready);
    modport slave  (input mem_req, input mem_addr, output mem_rdata, output mem_ready);
endinterface

// File: rtl/instr_fetch_unit.sv
// Multicycle RV32I fetch stage: owns the PC, runs the variable-latency memory read,
// latches the instruction register and decodes its fields for the control FSM.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fetch_req_i,
    input  logic                       pc_write_i,
    input  logic [31:0]                pc_target_i,
    input  logic                       fault_clr_i,
    instr_fetch_unit_if.master         mem,
    output logic                       busy_o,
    output logic                       instr_valid_o,
    output logic                       fault_o,
    output logic [1:0]                 fault_code_o,
    output logic [31:0]                pc_o,
    output logic [31:0]                instr_pc_o,
    output logic [31:0]                instr_o,
    output logic [6:0]                 opcode_o,
    output logic [4:0]                 rd_o,
    output logic [2:0]                 funct3_o,
    output logic [4:0]                 rs1_o,
    output logic [4:0]                 rs2_o,
    output logic [6:0]                 funct7_o,
    output logic [31:0]                imm_o
);

    localparam int          CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_FAULT
    } state_e;

    typedef enum logic [1:0] {
        FC_NONE     = 2'b00,
        FC_MISALIGN = 2'b01,
        FC_TIMEOUT  = 2'b10
    } fault_code_e;

    state_e          state_q;
    fault_code_e     fault_code_q;
    logic [31:0]     pc_q;
    logic [31:0]     instr_pc_q;
    logic [31:0]     ir_q;
    logic [CNT_W-1:0] cnt_q;
    logic            mem_req_q;
    logic            busy_q;
    logic            fault_q;
    logic            instr_valid_q;

    // Address a fetch issued this cycle would use: a same-cycle jump target wins.
    logic [31:0] pc_d;
    assign pc_d = pc_write_i ? (pc_target_i & ~32'h1) : pc_q;

    // NOTE: every register below is assigned with <= so all state updates
    // see the values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            fault_code_q  <= FC_NONE;
            pc_q          <= RESET_PC;
            instr_pc_q    <= RESET_PC;
            ir_q          <= NOP;
            cnt_q         <= '0;
            mem_req_q     <= 1'b0;
            busy_q        <= 1'b0;
            fault_q       <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            instr_valid_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (pc_write_i) pc_q <= pc_d;
                    if (fetch_req_i) begin
                        if (pc_d[1:0] != 2'b00) begin
                            state_q      <= S_FAULT;
                            fault_q      <= 1'b1;
                            fault_code_q <= FC_MISALIGN;
                        end else begin
                            state_q   <= S_BUSY;
                            busy_q    <= 1'b1;
                            mem_req_q <= 1'b1;
                            cnt_q     <= '0;
                        end
                    end
                end
                S_BUSY: begin
                    if (mem.mem_ready) begin
                        ir_q          <= mem.mem_rdata;
                        instr_pc_q    <= pc_q;
                        pc_q          <= pc_q + 32'd4;
                        instr_valid_q <= 1'b1;
                        state_q       <= S_IDLE;
                        busy_q        <= 1'b0;
                        mem_req_q     <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q      <= S_FAULT;
                        busy_q       <= 1'b0;
                        mem_req_q    <= 1'b0;
                        fault_q      <= 1'b1;
                        fault_code_q <= FC_TIMEOUT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_FAULT: begin
                    if (fault_clr_i) begin
                        state_q      <= S_IDLE;
                        fault_q      <= 1'b0;
                        fault_code_q <= FC_NONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem.mem_req  = mem_req_q;
    assign mem.mem_addr = pc_q;

    assign busy_o        = busy_q;
    assign instr_valid_o = instr_valid_q;
    assign fault_o       = fault_q;
    assign fault_code_o  = fault_code_q;
    assign pc_o          = pc_q;
    assign instr_pc_o    = instr_pc_q;
    assign instr_o       = ir_q;
    assign opcode_o      = ir_q[6:0];
    assign rd_o          = ir_q[11:7];
    assign funct3_o      = ir_q[14:12];
    assign rs1_o         = ir_q[19:15];
    assign rs2_o         = ir_q[24:20];
    assign funct7_o      = ir_q[31:25];

    // NOTE: imm_o gets a default before the case so no opcode path can infer a latch.
    always_comb begin
        imm_o = 32'b0;
        unique case (ir_q[6:0])
            7'b0010011, 7'b0000011, 7'b1100111:
                imm_o = {{20{ir_q[31]}}, ir_q[31:20]};
            7'b0100011:
                imm_o = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
            7'b1100011:
                imm_o = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                imm_o = {ir_q[31:12], 12'b0};
            7'b1101111:
                imm_o = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
            default:
                imm_o = 32'b0;
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit: reset, wait states, jumps,
// immediate decode, misaligned and timeout faults, and reset during an access.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_req = 1'b0;
    logic        pc_write = 1'b0;
    logic [31:0] pc_target = '0;
    logic        fault_clr = 1'b0;
    logic        busy, instr_valid, fault;
    logic [1:0]  fault_code;
    logic [31:0] pc, instr_pc, instr, imm;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;

    int tests = 0;
    int fails = 0;

    instr_fetch_unit_if mem_bus ();

    instr_fetch_unit #(.RESET_PC(32'h0), .TIMEOUT(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_req_i   (fetch_req),
        .pc_write_i    (pc_write),
        .pc_target_i   (pc_target),
        .fault_clr_i   (fault_clr),
        .mem           (mem_bus.master),
        .busy_o        (busy),
        .instr_valid_o (instr_valid),
        .fault_o       (fault),
        .fault_code_o  (fault_code),
        .pc_o          (pc),
        .instr_pc_o    (instr_pc),
        .instr_o       (instr),
        .opcode_o      (opcode),
        .rd_o          (rd),
        .funct3_o      (funct3),
        .rs1_o         (rs1),
        .rs2_o         (rs2),
        .funct7_o      (funct7),
        .imm_o         (imm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait fetch at the current pc; checks the latched word and immediate.
    task automatic fetch0(input string tag, input logic [31:0] word, input logic [31:0] exp_imm);
        logic [31:0] start_pc;
        start_pc = pc;
        fetch_req = 1'b1;
        mem_bus.mem_ready = 1'b1;
        mem_bus.mem_rdata = word;
        step();
        fetch_req = 1'b0;
        check({tag, "_req"}, {31'b0, mem_bus.mem_req}, 32'd1);
        step();
        mem_bus.mem_ready = 1'b0;
        check({tag, "_valid"}, {31'b0, instr_valid}, 32'd1);
        check({tag, "_instr"}, instr, word);
        check({tag, "_imm"}, imm, exp_imm);
        check({tag, "_pc"}, pc, start_pc + 32'd4);
    endtask

    typedef struct {
        string       tag;
        logic [31:0] word;
        logic [31:0] imm;
    } imm_vec_t;

    imm_vec_t vecs[4] = '{
        '{"lui",  32'h1234_50B7, 32'h1234_5000},
        '{"jal",  32'hFFDF_F0EF, 32'hFFFF_FFFC},
        '{"lw",   32'hFFC0_A103, 32'hFFFF_FFFC},
        '{"rtyp", 32'hFFF0_0033, 32'h0000_0000}
    };

    initial begin
        int n;
        logic seen_req;
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = '0;

        // T1 reset
        #12;
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_req", {31'b0, mem_bus.mem_req}, 32'd0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_fault", {31'b0, fault}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        step();

        // T2 zero-wait fetch, latency N+1 / N+2
        fetch_req = 1'b1;
        mem_bus.mem_ready = 1'b1;
        mem_bus.mem_rdata = 32'h0050_0093;
        step();
        fetch_req = 1'b0;
        check("t2_req", {31'b0, mem_bus.mem_req}, 32'd1);
        check("t2_addr", mem_bus.mem_addr, 32'h0);
        check("t2_busy", {31'b0, busy}, 32'd1);
        check("t2_early_valid", {31'b0, instr_valid}, 32'd0);
        step();
        mem_bus.mem_ready = 1'b0;
        check("t2_valid", {31'b0, instr_valid}, 32'd1);
        check("t2_opcode", {25'b0, opcode}, 32'h13);
        check("t2_rd", {27'b0, rd}, 32'd1);
        check("t2_imm", imm, 32'd5);
        check("t2_instr_pc", instr_pc, 32'h0);
        check("t2_pc", pc, 32'h4);
        check("t2_req_drop", {31'b0, mem_bus.mem_req}, 32'd0);
        step();
        check("t2_valid_pulse", {31'b0, instr_valid}, 32'd0);

        // T3 three wait states
        mem_bus.mem_rdata = 32'h0020_A423;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            check("t3_addr_stable", mem_bus.mem_addr, 32'h4);
            if (mem_bus.mem_req) n++;
            step();
        end
        mem_bus.mem_ready = 1'b1;
        if (mem_bus.mem_req) n++;
        check("t3_addr_last", mem_bus.mem_addr, 32'h4);
        step();
        mem_bus.mem_ready = 1'b0;
        check("t3_req_cycles", n, 4);
        check("t3_valid", {31'b0, instr_valid}, 32'd1);
        check("t3_imm", imm, 32'd8);
        check("t3_rs1", {27'b0, rs1}, 32'd1);
        check("t3_rs2", {27'b0, rs2}, 32'd2);
        check("t3_funct3", {29'b0, funct3}, 32'd2);
        check("t3_instr_pc", instr_pc, 32'h4);
        check("t3_pc", pc, 32'h8);

        // T4 jump and fetch in the same cycle
        pc_write = 1'b1;
        pc_target = 32'h100;
        fetch_req = 1'b1;
        mem_bus.mem_ready = 1'b1;
        mem_bus.mem_rdata = 32'hFE00_0EE3;
        step();
        pc_write = 1'b0;
        fetch_req = 1'b0;
        check("t4_addr", mem_bus.mem_addr, 32'h100);
        step();
        mem_bus.mem_ready = 1'b0;
        check("t4_imm", imm, 32'hFFFF_FFFC);
        check("t4_pc", pc, 32'h104);
        check("t4_instr_pc", instr_pc, 32'h100);
        check("t4_funct7", {25'b0, funct7}, 32'h7F);

        foreach (vecs[i]) fetch0(vecs[i].tag, vecs[i].word, vecs[i].imm);

        // bit0 of the target is dropped on load
        pc_write = 1'b1;
        pc_target = 32'h201;
        step();
        pc_write = 1'b0;
        check("bit0_forced", pc, 32'h200);

        // T5 misaligned fetch
        pc_write = 1'b1;
        pc_target = 32'h102;
        step();
        pc_write = 1'b0;
        fetch_req = 1'b1;
        seen_req = mem_bus.mem_req;
        step();
        fetch_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            seen_req |= mem_bus.mem_req;
            step();
        end
        check("t5_fault", {31'b0, fault}, 32'd1);
        check("t5_code", {30'b0, fault_code}, 32'd1);
        check("t5_no_req", {31'b0, seen_req}, 32'd0);
        check("t5_pc_frozen", pc, 32'h102);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        check("t5_clr_fault", {31'b0, fault}, 32'd0);
        check("t5_clr_code", {30'b0, fault_code}, 32'd0);

        // T6 timeout
        pc_write = 1'b1;
        pc_target = 32'h0;
        step();
        pc_write = 1'b0;
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        n = 0;
        while (mem_bus.mem_req && n < 40) begin
            n++;
            step();
        end
        check("t6_busy_cycles", n, 16);
        check("t6_fault", {31'b0, fault}, 32'd1);
        check("t6_code", {30'b0, fault_code}, 32'd2);
        check("t6_req_drop", {31'b0, mem_bus.mem_req}, 32'd0);
        check("t6_instr_frozen", instr, 32'hFFF0_0033);
        fetch_req = 1'b1;
        step();
        fetch_req = 1'b0;
        check("t6_fetch_ignored", {31'b0, mem_bus.mem_req}, 32'd0);
        check("t6_still_fault", {30'b0, fault_code}, 32'd2);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;

        // T6b reset in the middle of an access
        pc_write = 1'b1;
        pc_target = 32'h40;
        fetch_req = 1'b1;
        step();
        pc_write = 1'b0;
        fetch_req = 1'b0;
        check("t6b_req", {31'b0, mem_bus.mem_req}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t6b_req_async", {31'b0, mem_bus.mem_req}, 32'd0);
        check("t6b_busy", {31'b0, busy}, 32'd0);
        check("t6b_pc", pc, 32'h0);
        step();
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
